// File: rtl/battery_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : battery_pkg                                                |
// | Brief   : Mode encoding, speed codes and default rate constants for  |
// |           the battery manager, fan FSM and display driver.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package battery_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE      = 2'd0,
        MODE_CHARGE    = 2'd1,
        MODE_DISCHARGE = 2'd2,
        MODE_LOCKOUT   = 2'd3
    } batt_mode_e;

    localparam logic [1:0] c_speed_neutral = 2'd0;
    localparam logic [1:0] c_speed_low     = 2'd1;
    localparam logic [1:0] c_speed_med     = 2'd2;
    localparam logic [1:0] c_speed_high    = 2'd3;

    // Base ticks (50 ms) per level step
    localparam int c_def_chg_t0 = 2;
    localparam int c_def_chg_t1 = 5;
    localparam int c_def_chg_t2 = 10;
    localparam int c_def_chg_t3 = 20;
    localparam int c_def_dis_t1 = 10;
    localparam int c_def_dis_t2 = 5;
    localparam int c_def_dis_t3 = 2;

endpackage
`default_nettype wire

// File: rtl/batt_rate_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : batt_rate_divider                                          |
// | Brief   : Counts base ticks and pulses step once every period ticks. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module batt_rate_divider #(
    parameter int DIV_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             step
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt >= (period - DIV_W'(1)));
    // Clear wins over a coincident tick so a new rate always starts from zero
    assign step   = en && tick && !clr && w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && tick) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/battery_manager_v2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : battery_manager_v2                                         |
// | Brief   : Charge-level tracker with mode FSM, hysteretic low flag    |
// |           and empty lockout. Optional BATT_STATS_EN adds cycle_cnt.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module battery_manager_v2
    import battery_pkg::*;
#(
    parameter int LEVEL_W     = 8,
    parameter int MAX_LEVEL   = 99,
    parameter int INIT_LEVEL  = 99,
    parameter int LOW_SET     = 20,
    parameter int LOW_CLR     = 25,
    parameter int RECOVER_LVL = 5,
    parameter int DIV_W       = 6,
    parameter int CHG_T0      = c_def_chg_t0,
    parameter int CHG_T1      = c_def_chg_t1,
    parameter int CHG_T2      = c_def_chg_t2,
    parameter int CHG_T3      = c_def_chg_t3,
    parameter int DIS_T1      = c_def_dis_t1,
    parameter int DIS_T2      = c_def_dis_t2,
    parameter int DIS_T3      = c_def_dis_t3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               charge_en,
    input  logic [1:0]         speed,
    output logic [LEVEL_W-1:0] level,
    output logic               empty,
    output logic               full,
    output logic               low,
    output logic [1:0]         mode,
    output logic               fan_allow
`ifdef BATT_STATS_EN
    ,
    output logic [15:0]        cycle_cnt
`endif
);

    batt_mode_e         r_mode;
    batt_mode_e         r_mode_d;
    batt_mode_e         w_mode_next;
    logic [1:0]         r_speed_d;
    logic [LEVEL_W-1:0] r_level;
    logic               r_low;
    logic [DIV_W-1:0]   w_period;
    logic               w_div_en;
    logic               w_div_clr;
    logic               w_step;

    assign level     = r_level;
    assign mode      = r_mode;
    assign low       = r_low;
    assign empty     = (r_level == '0);
    assign full      = (r_level == LEVEL_W'(MAX_LEVEL));
    assign fan_allow = (r_mode != MODE_LOCKOUT);

    // Lockout only recharges while the charger is connected
    assign w_div_en  = (r_mode == MODE_CHARGE) || (r_mode == MODE_DISCHARGE) ||
                       ((r_mode == MODE_LOCKOUT) && charge_en);
    assign w_div_clr = (r_mode != r_mode_d) || (speed != r_speed_d);

    always_comb begin
        w_period = DIV_W'(CHG_T0);
        case (r_mode)
            MODE_CHARGE: begin
                case (speed)
                    c_speed_low:  w_period = DIV_W'(CHG_T1);
                    c_speed_med:  w_period = DIV_W'(CHG_T2);
                    c_speed_high: w_period = DIV_W'(CHG_T3);
                    default:      w_period = DIV_W'(CHG_T0);
                endcase
            end
            MODE_DISCHARGE: begin
                case (speed)
                    c_speed_med:  w_period = DIV_W'(DIS_T2);
                    c_speed_high: w_period = DIV_W'(DIS_T3);
                    default:      w_period = DIV_W'(DIS_T1);
                endcase
            end
            default: w_period = DIV_W'(CHG_T0);
        endcase
    end

    always_comb begin
        w_mode_next = r_mode;
        if (r_level == '0) begin
            w_mode_next = MODE_LOCKOUT;
        end else if (r_mode == MODE_LOCKOUT) begin
            if (r_level >= LEVEL_W'(RECOVER_LVL)) begin
                w_mode_next = MODE_IDLE;
            end
        end else if (charge_en) begin
            w_mode_next = MODE_CHARGE;
        end else if (speed != c_speed_neutral) begin
            w_mode_next = MODE_DISCHARGE;
        end else begin
            w_mode_next = MODE_IDLE;
        end
    end

    batt_rate_divider #(
        .DIV_W (DIV_W)
    ) u_rate_divider (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .en     (w_div_en),
        .clr    (w_div_clr),
        .period (w_period),
        .step   (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= MODE_IDLE;
            r_mode_d  <= MODE_IDLE;
            r_speed_d <= c_speed_neutral;
            r_level   <= LEVEL_W'(INIT_LEVEL);
            r_low     <= (INIT_LEVEL <= LOW_SET);
        end else begin
            r_mode    <= w_mode_next;
            r_mode_d  <= r_mode;
            r_speed_d <= speed;
            if (r_level <= LEVEL_W'(LOW_SET)) begin
                r_low <= 1'b1;
            end else if (r_level >= LEVEL_W'(LOW_CLR)) begin
                r_low <= 1'b0;
            end
            if (w_step) begin
                if (r_mode == MODE_DISCHARGE) begin
                    if (r_level != '0) begin
                        r_level <= r_level - LEVEL_W'(1);
                    end
                end else if (r_level != LEVEL_W'(MAX_LEVEL)) begin
                    r_level <= r_level + LEVEL_W'(1);
                end
            end
        end
    end

`ifdef BATT_STATS_EN
    logic [15:0] r_cycle_cnt;
    logic        w_enter_lock;
    logic        w_hit_full;

    assign cycle_cnt    = r_cycle_cnt;
    assign w_enter_lock = (w_mode_next == MODE_LOCKOUT) && (r_mode != MODE_LOCKOUT);
    assign w_hit_full   = w_step && (r_mode != MODE_DISCHARGE) &&
                          (r_level == LEVEL_W'(MAX_LEVEL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if ((w_enter_lock || w_hit_full) && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_battery_manager_v2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_battery_manager_v2                                      |
// | Brief   : Directed + random stimulus against a behavioural model.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_battery_manager_v2;

    localparam int MAXL = 99;
    localparam int INIT = 99;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       charge_en = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [7:0] level;
    logic       empty, full, low, fan_allow;
    logic [1:0] mode;
`ifdef BATT_STATS_EN
    logic [15:0] cycle_cnt;
`endif

    battery_manager_v2 dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .charge_en (charge_en),
        .speed     (speed),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .low       (low),
        .mode      (mode),
        .fan_allow (fan_allow)
`ifdef BATT_STATS_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: level in units, mode 0..3, ticks accumulated
    int m_level, m_mode, m_pmode, m_pspeed, m_acc, m_low, m_stats;
    int chg_t[4] = '{2, 5, 10, 20};
    int dis_t[4] = '{1, 10, 5, 2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clock(input bit r, input bit t, input bit ce, input int sp);
        int per, nxt;
        bit stp, active;
        if (r) begin
            m_level = INIT; m_mode = 0; m_pmode = 0; m_pspeed = 0;
            m_acc = 0; m_low = (INIT <= 20); m_stats = 0;
            return;
        end
        per    = (m_mode == 3) ? chg_t[0] : (m_mode == 1) ? chg_t[sp] : dis_t[sp];
        active = (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && ce);
        stp    = 1'b0;
        if (m_mode != m_pmode || sp != m_pspeed) m_acc = 0;
        else if (active && t) begin
            m_acc++;
            if (m_acc >= per) begin m_acc = 0; stp = 1'b1; end
        end
        if (m_level == 0) nxt = 3;
        else if (m_mode == 3) nxt = (m_level >= 5) ? 0 : 3;
        else if (ce) nxt = 1;
        else if (sp != 0) nxt = 2;
        else nxt = 0;
        if (nxt == 3 && m_mode != 3 && m_stats < 65535) m_stats++;
        if (stp && m_mode != 2 && m_level == MAXL - 1 && m_stats < 65535) m_stats++;
        if (m_level <= 20) m_low = 1;
        else if (m_level >= 25) m_low = 0;
        if (stp) begin
            if (m_mode == 2) m_level = (m_level > 0) ? m_level - 1 : 0;
            else m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
        end
        m_pmode = m_mode; m_pspeed = sp; m_mode = nxt;
    endtask

    task automatic compare_all();
        chk("level", level, m_level);
        chk("mode", mode, m_mode);
        chk("empty", empty, m_level == 0);
        chk("full", full, m_level == MAXL);
        chk("low", low, m_low);
        chk("fan_allow", fan_allow, m_mode != 3);
`ifdef BATT_STATS_EN
        chk("cycle_cnt", cycle_cnt, m_stats);
`endif
    endtask

    task automatic cyc(input bit r, input bit t, input bit ce, input int sp);
        rst = r; tick = t; charge_en = ce; speed = sp[1:0];
        @(posedge clk);
        model_clock(r, t, ce, sp);
        #1;
        compare_all();
    endtask

    task automatic do_ticks(input int n, input bit ce, input int sp);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, ce, sp);
            cyc(1'b0, 1'b0, ce, sp);
        end
    endtask

    task automatic run_to_level(input int target, input bit ce, input int sp, input string tag);
        int k = 0;
        while (m_level != target && k < 400) begin
            do_ticks(1, ce, sp);
            k++;
        end
        chk(tag, level, target);
    endtask

    initial begin
        // Reset
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("rst_level", level, 99);
        chk("rst_mode", mode, 0);
        chk("rst_fan", fan_allow, 1);
        chk("rst_low", low, 0);
        chk("rst_full", full, 1);
        chk("rst_empty", empty, 0);

        // Discharge at speed 3, then rate switch to speed 1
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 3);
        do_ticks(20, 1'b0, 3);
        chk("dis20", level, 89);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1);
        do_ticks(9, 1'b0, 1);
        chk("sw_hold", level, 89);
        do_ticks(1, 1'b0, 1);
        chk("sw_step", level, 88);

        // Hysteresis
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 3);
        run_to_level(21, 1'b0, 3, "to21");
        run_to_level(20, 1'b0, 3, "to20");
        chk("low_set", low, 1);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 0);
        run_to_level(24, 1'b1, 0, "to24");
        chk("low_hold", low, 1);
        run_to_level(25, 1'b1, 0, "to25");
        cyc(1'b0, 1'b0, 1'b1, 0);
        chk("low_clr", low, 0);

        // Lockout and recovery
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 3);
        run_to_level(0, 1'b0, 3, "to0");
        cyc(1'b0, 1'b0, 1'b0, 3);
        chk("lock_mode", mode, 3);
        chk("lock_fan", fan_allow, 0);
        chk("lock_empty", empty, 1);
        do_ticks(10, 1'b0, 3);
        chk("lock_nodis", level, 0);
        do_ticks(10, 1'b1, 3);
        chk("recover_lvl", level, 5);
        chk("recover_mode", mode, 0);
        chk("recover_fan", fan_allow, 1);

        // Saturation with toggling charge_en mid-interval
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 0);
        run_to_level(50, 1'b1, 0, "to50");
        do_ticks(1, 1'b1, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 0);
        do_ticks(1, 1'b1, 0);
        chk("toggle_hold", level, 50);
        do_ticks(1, 1'b1, 0);
        chk("toggle_step", level, 51);
        run_to_level(98, 1'b1, 0, "to98");
        cyc(1'b0, 1'b0, 1'b1, 2);
        do_ticks(20, 1'b1, 2);
        chk("sat99", level, 99);

        // Full empty -> recover -> full stats cycle, then reset mid-sequence
        cyc(1'b1, 1'b0, 1'b0, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 3);
        run_to_level(0, 1'b0, 3, "st_to0");
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 0);
        run_to_level(99, 1'b1, 0, "st_to99");
`ifdef BATT_STATS_EN
        chk("stats2", cycle_cnt, 2);
`endif
        do_ticks(30, 1'b0, 2);
        cyc(1'b1, 1'b0, 1'b0, 2);
        chk("mid_rst_level", level, 99);
`ifdef BATT_STATS_EN
        chk("mid_rst_stats", cycle_cnt, 0);
`endif

        // Random stimulus
        begin
            bit ce = 1'b0;
            int sp = 0;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom_range(0, 39) == 0) ce = ~ce;
                if ($urandom_range(0, 29) == 0) sp = $urandom_range(0, 3);
                cyc($urandom_range(0, 1999) == 0, $urandom_range(0, 2) == 0, ce, sp);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/battery_manager_v2.md
Name: battery_manager_v2

Overview:
Parametrised successor to the fan controller's battery model. Tracks a charge level with parameterised full-scale and width, and charges or discharges at per-speed rates. Rates are derived internally from a single base tick instead of several external timers. Adds an explicit mode FSM, low-battery warning with hysteresis, and an empty-lockout that holds the fan off until the battery recovers. Sits between the 50 ms timebase and the fan speed FSM/display logic.

Parameters:
LEVEL_W, 8, width of level counter
MAX_LEVEL, 99, full-scale level; must be < 2**LEVEL_W
INIT_LEVEL, 99, level after reset
LOW_SET, 20, low flag asserts when level <= LOW_SET
LOW_CLR, 25, low flag deasserts when level >= LOW_CLR; LOW_CLR > LOW_SET
RECOVER_LVL, 5, level at which lockout releases
DIV_W, 6, width of interval counter
CHG_T0/CHG_T1/CHG_T2/CHG_T3, 2/5/10/20, base ticks per +1 while charging at speed 0..3
DIS_T1/DIS_T2/DIS_T3, 10/5/2, base ticks per -1 while discharging at speed 1..3; all T values in 1..2**DIV_W-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick  input  1  one-cycle pulse every 50 ms
charge_en  input  1  charger switch (sw0)
speed  input  2  requested fan speed; 0 = neutral
level  output  LEVEL_W  current level 0..MAX_LEVEL
empty  output  1  level == 0
full  output  1  level == MAX_LEVEL
low  output  1  hysteretic low-battery warning
mode  output  2  FSM state encoding
fan_allow  output  1  0 in lockout; fan FSM forces neutral when 0

Behaviour:
- Reset (sync, rst=1 at clk edge): level=INIT_LEVEL, mode=IDLE, interval counter=0, low=(INIT_LEVEL<=LOW_SET), fan_allow=1. Reset mid-interval discards the partial count.
- The FSM is evaluated on every clk. Priority order for transitions, highest first:
  - LOCKOUT: entered from any state when level reaches 0. In LOCKOUT, fan_allow=0 and discharge is disabled. Exits to IDLE only when level >= RECOVER_LVL. Charging proceeds in LOCKOUT at the CHG_T0 rate regardless of speed.
  - CHARGE: charge_en=1. Charging takes priority over discharge; there is no simultaneous discharge while charging at non-zero speed.
  - DISCHARGE: charge_en=0 and speed!=0.
  - IDLE: charge_en=0 and speed==0. Level holds.
- Encoding: IDLE=0, CHARGE=1, DISCHARGE=2, LOCKOUT=3.
- Interval counter:
  - Increments on tick while in CHARGE, DISCHARGE or LOCKOUT.
  - When it reaches T(mode,speed)-1 on a tick, it wraps to 0 and a level step fires in the same cycle. The new level is visible the following cycle.
  - Cleared when mode or speed changes, so the first step after any change comes a full interval later.
  - Held in IDLE.
- Saturation: charge step at MAX_LEVEL has no effect; the counter still wraps. Discharge step at 0 is impossible because of LOCKOUT.
- empty and full are combinational decodes of the registered level.
- low is registered. It sets the cycle after level <= LOW_SET and clears the cycle after level >= LOW_CLR; otherwise it holds.
- tick held high for several cycles is treated as one tick per clk; the source guarantees single-cycle pulses.

Optional Feature:
BATT_STATS_EN
- Defined: adds output cycle_cnt [15:0]. It increments, saturating at 0xFFFF, on every transition into LOCKOUT. It also increments on each charge step that lands the level exactly on MAX_LEVEL. Sync-reset to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package battery_pkg:
  - mode enum/localparams (IDLE/CHARGE/DISCHARGE/LOCKOUT)
  - speed encoding constants
  - default rate constants, reused by the fan FSM and the display driver
- One natural sub-module: batt_rate_divider. It takes tick, an enable, a clear and a period, and returns the step pulse. The top module holds the FSM, level register and flags.

Test Plan:
1. Reset: rst=1 for 2 cycles -> level=99, mode=0, fan_allow=1, low=0, full=1, empty=0.
2. Discharge: charge_en=0, speed=3, 20 ticks -> level=89 (one step per 2 ticks). Switch to speed=1 -> the next step arrives exactly 10 ticks after the switch.
3. Hysteresis: from level 21, discharge at speed 3 -> low=1 the cycle after level hits 20. Charge at speed 0 -> low stays 1 at levels 21..24 and clears the cycle after level=25.
4. Lockout: discharge to 0 -> mode=3, fan_allow=0, empty=1. speed=3, charge_en=0 -> level stays 0. charge_en=1, 10 ticks -> level=5, mode leaves 3 next cycle, fan_allow=1.
5. Saturation and priority: level=98, charge_en=1, speed=2, 20 ticks -> level=99 and stays 99. Toggling charge_en mid-interval clears the counter; no step is lost or doubled.
6. BATT_STATS_EN build: one empty→recover→full cycle -> cycle_cnt=2. Reset mid-sequence -> cycle_cnt=0, level=99.
